// File: rtl/floating_point_adder.sv
// Single-precision adder with truncating rounding.
// Result and saturation flag are registered one cycle after a/b.
module floating_point_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        overflow
);

  logic [7:0]        ea, eb, el, es, diff;
  logic [23:0]       ma, mb, ml, ms, ms_sh;
  logic              sl, ss, a_big;
  logic [24:0]       add;
  logic [22:0]       frac;
  logic [4:0]        lz;
  logic              found;
  logic signed [9:0] exp_n;
  logic [31:0]       res;
  logic              ovf;

  assign ea = a[30:23];
  assign eb = b[30:23];
  assign ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
  assign mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};

  always_comb begin
    a_big = {ea, ma} >= {eb, mb};
    el    = a_big ? ea : eb;
    es    = a_big ? eb : ea;
    ml    = a_big ? ma : mb;
    ms    = a_big ? mb : ma;
    sl    = a_big ? a[31] : b[31];
    ss    = a_big ? b[31] : a[31];
    diff  = el - es;
    ms_sh = (diff >= 8'd24) ? 24'd0 : (ms >> diff);
    if (sl == ss)
      add = {1'b0, ml} + {1'b0, ms_sh};
    else
      add = {1'b0, ml} - {1'b0, ms_sh};
  end

  // Distance from bit 23 to the leading one of the uncarried sum.
  always_comb begin
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && add[i]) begin
        lz    = 5'(23 - i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    if (add[24]) begin
      frac  = add[23:1];
      exp_n = $signed({2'b00, el}) + 10'sd1;
    end else begin
      frac  = add[22:0] << lz;
      exp_n = $signed({2'b00, el})
            - $signed({5'b00000, lz});
    end
  end

  always_comb begin
    res = 32'h0;
    ovf = 1'b0;
    if (ea == 8'hFF || eb == 8'hFF) begin
      res = {(ea == 8'hFF) ? a[31] : b[31],
             31'h7FFFFFFF};
      ovf = 1'b1;
    end else if (add == 25'd0) begin
      res = 32'h0;
    end else if (exp_n <= 10'sd0) begin
      res = 32'h0;
    end else if (exp_n >= 10'sd255) begin
      res = {sl, 31'h7FFFFFFF};
      ovf = 1'b1;
    end else begin
      res = {sl, exp_n[7:0], frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= 32'h0;
      overflow <= 1'b0;
    end else begin
      sum      <= res;
      overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_floating_point_adder.sv
// Directed-vector bench for floating_point_adder.
// Each scenario task drives operands and checks the registered result.
module tb_floating_point_adder;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        overflow;

  int checks;
  int errors;

  floating_point_adder dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    a = 32'h7F7FFFFF;
    b = 32'h7F7FFFFF;
    @(posedge clk);
    #1;
    checks++;
    if (sum !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: sum=%h ovf=%b want 00000000 0",
               sum, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overflow;
    logic [31:0] va [2];
    logic [31:0] vb [2];
    logic [31:0] ve [2];
    va = '{32'h7F7FFFFF, 32'hFF7FFFFF};
    vb = '{32'h7F7FFFFF, 32'hFF7FFFFF};
    ve = '{32'h7FFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 2; i++) begin
      drive(va[i], vb[i]);
      checks++;
      if (sum !== ve[i] || overflow !== 1'b1) begin
        errors++;
        $display("FAIL overflow[%0d]: sum=%h ovf=%b want %h 1",
                 i, sum, overflow, ve[i]);
      end
    end
  endtask

  task automatic test_mixed_sign;
    drive(32'h40A851EC, 32'hC18C6666);
    checks++;
    if (sum !== 32'hC144A3D6 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mixed: sum=%h ovf=%b want C144A3D6 0",
               sum, overflow);
    end
    drive(32'h3F800000, 32'hBF800000);
    checks++;
    if (sum !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL cancel: sum=%h ovf=%b want 00000000 0",
               sum, overflow);
    end
  endtask

  task automatic test_truncation;
    drive(32'h41139168, 32'h45AFE8CD);
    checks++;
    if (sum !== 32'h45B03295 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL trunc0: sum=%h ovf=%b want 45B03295 0",
               sum, overflow);
    end
    drive(32'hC261A3D7, 32'hC3D2D74C);
    checks++;
    if (sum !== 32'hC3EF0BC6 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL trunc1: sum=%h ovf=%b want C3EF0BC6 0",
               sum, overflow);
    end
  endtask

  task automatic test_carry;
    drive(32'h47AEDB0F, 32'h48EAFC7C);
    checks++;
    if (sum !== 32'h490B599F || overflow !== 1'b0) begin
      errors++;
      $display("FAIL carry0: sum=%h ovf=%b want 490B599F 0",
               sum, overflow);
    end
    drive(32'hC5BB09D7, 32'hC5AA98CD);
    checks++;
    if (sum !== 32'hC632D152 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL carry1: sum=%h ovf=%b want C632D152 0",
               sum, overflow);
    end
  endtask

  task automatic test_zeros;
    drive(32'h00000000, 32'h00000000);
    checks++;
    if (sum !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero: sum=%h ovf=%b want 00000000 0",
               sum, overflow);
    end
    drive(32'h00000001, 32'h3F800000);
    checks++;
    if (sum !== 32'h3F800000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL denorm: sum=%h ovf=%b want 3F800000 0",
               sum, overflow);
    end
    // 1.0*2^-126 minus 1.000..1*2^-126 leaves one ulp: underflow
    drive(32'h00800000, 32'h80800001);
    checks++;
    if (sum !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow: sum=%h ovf=%b want 00000000 0",
               sum, overflow);
    end
  endtask

  task automatic test_special;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] ve [3];
    va = '{32'h7F800000, 32'h3F800000, 32'hFF800000};
    vb = '{32'h3F800000, 32'hFF800000, 32'h7F800000};
    ve = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i]);
      checks++;
      if (sum !== ve[i] || overflow !== 1'b1) begin
        errors++;
        $display("FAIL special[%0d]: sum=%h ovf=%b want %h 1",
                 i, sum, overflow, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] ve [4];
    logic        vo [4];
    va = '{32'h7F7FFFFF, 32'h47AEDB0F,
           32'h3F800000, 32'h40A851EC};
    vb = '{32'h7F7FFFFF, 32'h48EAFC7C,
           32'hBF800000, 32'hC18C6666};
    ve = '{32'h7FFFFFFF, 32'h490B599F,
           32'h00000000, 32'hC144A3D6};
    vo = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i]);
      checks++;
      if (sum !== ve[i] || overflow !== vo[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: sum=%h ovf=%b want %h %b",
                 i, sum, overflow, ve[i], vo[i]);
      end
    end
  endtask

  task automatic test_reset_hold;
    drive(32'h40A851EC, 32'hC18C6666);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sum !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: sum=%h ovf=%b want 00000000 0",
               sum, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (sum !== 32'hC144A3D6 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: sum=%h ovf=%b want C144A3D6 0",
               sum, overflow);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a = 32'h0;
    b = 32'h0;
    test_reset();
    test_overflow();
    test_mixed_sign();
    test_truncation();
    test_carry();
    test_zeros();
    test_special();
    test_back_to_back();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
